// File: rtl/crypto_sched.sv
// Two-requester round-robin front end for the shared 16-bit crypto core.
// Sequences core reset/start/wait per job and returns results on one tagged response channel.
module crypto_sched #(
  parameter int RST_CYCLES = 2,
  parameter int BGN_CYCLES = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_mode,
  input  logic [15:0] req0_key,
  input  logic [15:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_mode,
  input  logic [15:0] req1_key,
  input  logic [15:0] req1_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic [15:0] rsp_key,
  output logic        crypto_rst_n,
  output logic        crypto_bgn,
  output logic [1:0]  crypto_mode,
  output logic [15:0] crypto_key,
  output logic [15:0] crypto_data,
  input  logic        crypto_fin,
  input  logic [15:0] crypto_key_out,
  input  logic [15:0] crypto_data_out,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CRST, START, WAIT, RESP} state_t;

  localparam logic [15:0] L_RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] L_BGN_LAST = 16'(BGN_CYCLES - 1);
  localparam logic [15:0] L_TIMEOUT  = 16'(TIMEOUT);

  state_t      r_state;
  logic        r_last;
  logic [15:0] r_cnt;
  logic        r_crst_n;
  logic        r_bgn;
  logic [1:0]  r_cmode;
  logic [15:0] r_ckey;
  logic [15:0] r_cdata;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic        r_rsp_err;
  logic [15:0] r_rsp_data;
  logic [15:0] r_rsp_key;

  logic        w_idle;
  logic        w_take0;
  logic        w_take1;
  logic        w_take;
  logic [1:0]  w_mode;
  logic [15:0] w_key;
  logic [15:0] w_data;
  logic        w_legal;
  logic        w_wait_done;

  // Each ready looks only at the other requester's valid, so no valid->ready loop exists.
  assign w_idle     = (r_state == IDLE) && !rst;
  assign req0_ready = w_idle && (!req1_valid || r_last);
  assign req1_ready = w_idle && (!req0_valid || !r_last);

  assign w_take0 = req0_valid && req0_ready;
  assign w_take1 = req1_valid && req1_ready;
  assign w_take  = w_take0 || w_take1;
  assign w_mode  = w_take1 ? req1_mode : req0_mode;
  assign w_key   = w_take1 ? req1_key  : req0_key;
  assign w_data  = w_take1 ? req1_data : req0_data;
  assign w_legal = (w_mode == 2'b01) || (w_mode == 2'b10);

  // Fin takes priority over an expiring timeout in the same cycle.
  assign w_wait_done = crypto_fin || (r_cnt == L_TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_crst_n    <= 1'b1;
      r_bgn       <= 1'b0;
      r_cmode     <= '0;
      r_ckey      <= '0;
      r_cdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_key   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_last   <= w_take1;
            r_rsp_id <= w_take1;
            r_cnt    <= '0;
            if (w_legal) begin
              r_state  <= CRST;
              r_crst_n <= 1'b0;
              r_cmode  <= w_mode;
              r_ckey   <= w_key;
              r_cdata  <= w_data;
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_key   <= '0;
            end
          end
        end
        CRST: begin
          if (r_cnt == L_RST_LAST) begin
            r_state  <= START;
            r_cnt    <= '0;
            r_crst_n <= 1'b1;
            r_bgn    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        START: begin
          if (r_cnt == L_BGN_LAST) begin
            r_state <= WAIT;
            r_cnt   <= '0;
            r_bgn   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        WAIT: begin
          if (w_wait_done) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !crypto_fin;
            r_rsp_data  <= crypto_fin ? crypto_data_out : 16'h0000;
            r_rsp_key   <= crypto_fin ? crypto_key_out  : 16'h0000;
            r_crst_n    <= crypto_fin;
            r_cmode     <= '0;
            r_ckey      <= '0;
            r_cdata     <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        RESP: begin
          // Ends the one-cycle core reset pulse that follows an abort.
          r_crst_n <= 1'b1;
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_err      = r_rsp_err;
  assign rsp_data     = r_rsp_data;
  assign rsp_key      = r_rsp_key;
  assign crypto_rst_n = r_crst_n && !rst;
  assign crypto_bgn   = r_bgn;
  assign crypto_mode  = r_cmode;
  assign crypto_key   = r_ckey;
  assign crypto_data  = r_cdata;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_crypto_sched.sv
// Scoreboard bench for crypto_sched: a stub core on the default instance,
// plus a second instance with TIMEOUT=20 whose core never finishes.
module tb_crypto_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_mode, req1_mode;
  logic [15:0] req0_key, req0_data, req1_key, req1_data;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data, rsp_key;
  logic        crypto_rst_n, crypto_bgn, crypto_fin, busy;
  logic [1:0]  crypto_mode;
  logic [15:0] crypto_key, crypto_data, crypto_key_out, crypto_data_out;

  logic        to_req0_valid, to_req0_ready, to_req1_valid, to_req1_ready;
  logic [1:0]  to_req0_mode, to_req1_mode;
  logic [15:0] to_req0_key, to_req0_data, to_req1_key, to_req1_data;
  logic        to_rsp_valid, to_rsp_ready, to_rsp_id, to_rsp_err;
  logic [15:0] to_rsp_data, to_rsp_key;
  logic        to_crst_n, to_bgn, to_fin, to_busy;
  logic [1:0]  to_cmode;
  logic [15:0] to_ckey, to_cdata, to_kout, to_dout;

  crypto_sched u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_key(req0_key), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_key(req1_key), .req1_data(req1_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .rsp_key(rsp_key),
    .crypto_rst_n(crypto_rst_n), .crypto_bgn(crypto_bgn), .crypto_mode(crypto_mode),
    .crypto_key(crypto_key), .crypto_data(crypto_data), .crypto_fin(crypto_fin),
    .crypto_key_out(crypto_key_out), .crypto_data_out(crypto_data_out), .busy(busy)
  );

  crypto_sched #(.TIMEOUT(20)) u_to (
    .clk(clk), .rst(rst),
    .req0_valid(to_req0_valid), .req0_ready(to_req0_ready), .req0_mode(to_req0_mode),
    .req0_key(to_req0_key), .req0_data(to_req0_data),
    .req1_valid(to_req1_valid), .req1_ready(to_req1_ready), .req1_mode(to_req1_mode),
    .req1_key(to_req1_key), .req1_data(to_req1_data),
    .rsp_valid(to_rsp_valid), .rsp_ready(to_rsp_ready), .rsp_id(to_rsp_id), .rsp_err(to_rsp_err),
    .rsp_data(to_rsp_data), .rsp_key(to_rsp_key),
    .crypto_rst_n(to_crst_n), .crypto_bgn(to_bgn), .crypto_mode(to_cmode),
    .crypto_key(to_ckey), .crypto_data(to_cdata), .crypto_fin(to_fin),
    .crypto_key_out(to_kout), .crypto_data_out(to_dout), .busy(to_busy)
  );

  // Stub core: raises fin fin_delay cycles after crypto_bgn falls, outputs are inputs XOR a mask.
  int          fin_delay;
  logic [15:0] xor_d, xor_k;
  logic [15:0] s_cnt;
  logic        s_arm;
  always @(posedge clk) begin
    if (!crypto_rst_n) begin
      crypto_fin <= 1'b0;
      s_arm      <= 1'b0;
      s_cnt      <= '0;
    end else if (crypto_bgn) begin
      s_arm <= 1'b1;
      s_cnt <= '0;
    end else if (s_arm && !crypto_fin) begin
      s_cnt <= s_cnt + 16'd1;
      if (int'(s_cnt) + 1 == fin_delay) begin
        crypto_fin      <= 1'b1;
        crypto_data_out <= crypto_data ^ xor_d;
        crypto_key_out  <= crypto_key ^ xor_k;
      end
    end
  end

  typedef struct {
    logic        id;
    logic        err;
    logic [15:0] data;
    logic [15:0] key;
  } rsp_t;
  rsp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input bit n, input logic [1:0] m, input logic [15:0] k,
                           input logic [15:0] d, input int budget, output bit ok);
    ok = 1'b0;
    if (n) begin req1_mode = m; req1_key = k; req1_data = d; req1_valid = 1'b1; end
    else   begin req0_mode = m; req0_key = k; req0_data = d; req0_valid = 1'b1; end
    for (int c = 0; c < budget; c++) begin
      #1;
      if ((n ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rsp_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, crypto_bgn, busy, crypto_rst_n} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, crypto_bgn, busy, crypto_rst_n});
    end
    checks++;
    if ({rsp_data, rsp_key, crypto_mode, crypto_key, crypto_data} !== 66'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 0", {rsp_data, rsp_key, crypto_mode, crypto_key, crypto_data});
    end
    checks++;
    if ({to_req0_ready, to_req1_ready, to_busy, to_cmode, to_ckey, to_cdata} !== 37'h0) begin
      errors++;
      $display("FAIL reset_to_inst: got %h expected 0", {to_req0_ready, to_req1_ready, to_busy, to_cmode, to_ckey, to_cdata});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({crypto_rst_n, busy, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL post_reset_idle: got rst_n/busy/valid=%b expected 100", {crypto_rst_n, busy, rsp_valid});
    end
  endtask

  task automatic test_single_encrypt();
    bit   ok;
    int   rst_low = 0, bgn_hi = 0, bgn_first = -1, fin_idx = -1, rsp_idx = -1;
    rsp_t e;
    fin_delay = 40;
    xor_d = 16'h59B3 ^ 16'hABCD;
    xor_k = 16'h1325 ^ 16'h1234;
    rsp_ready = 1'b1;
    exp_q.push_back('{1'b0, 1'b0, 16'hABCD, 16'h1234});
    drive_req(1'b0, 2'b01, 16'h1325, 16'h59B3, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL enc_accept: got no accept expected accept"); end
    for (int idx = 0; idx < 200; idx++) begin
      if (crypto_rst_n === 1'b0) rst_low++;
      if (crypto_bgn === 1'b1) begin
        if (bgn_first < 0) begin
          bgn_first = idx;
          checks++;
          if ({crypto_mode, crypto_key, crypto_data} !== {2'b01, 16'h1325, 16'h59B3}) begin
            errors++;
            $display("FAIL enc_core_drive: got %h expected %h", {crypto_mode, crypto_key, crypto_data},
                     {2'b01, 16'h1325, 16'h59B3});
          end
        end
        bgn_hi++;
      end
      if (crypto_fin === 1'b1 && fin_idx < 0) fin_idx = idx;
      if (rsp_valid === 1'b1) begin rsp_idx = idx; break; end
      @(negedge clk);
    end
    checks++;
    if (rst_low != 2) begin errors++; $display("FAIL enc_rst_cycles: got %0d expected 2", rst_low); end
    checks++;
    if (bgn_hi != 10 || bgn_first != 2) begin
      errors++;
      $display("FAIL enc_bgn_cycles: got %0d from %0d expected 10 from 2", bgn_hi, bgn_first);
    end
    checks++;
    if (rsp_idx < 0 || fin_idx < 0 || rsp_idx != fin_idx + 1) begin
      errors++;
      $display("FAIL enc_fin_latency: got rsp at %0d fin at %0d expected rsp one cycle after fin", rsp_idx, fin_idx);
    end
    if (rsp_idx >= 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rsp_id, rsp_err, rsp_data, rsp_key} !== {e.id, e.err, e.data, e.key}) begin
        errors++;
        $display("FAIL enc_rsp: got %h expected %h", {rsp_id, rsp_err, rsp_data, rsp_key}, {e.id, e.err, e.data, e.key});
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, crypto_mode, crypto_key, crypto_data} !== 35'h0) begin
      errors++;
      $display("FAIL enc_idle_after: got %h expected 0", {busy, crypto_mode, crypto_key, crypto_data});
    end
  endtask

  task automatic test_contention();
    int acc_fail = 0;
    do_reset();
    fin_delay = 3;
    xor_d = 16'h0F0F;
    xor_k = 16'hF0F0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{1'b0, 1'b0, (16'h1000 + 16'(k)) ^ 16'h0F0F, (16'h2000 + 16'(k)) ^ 16'hF0F0});
      exp_q.push_back('{1'b1, 1'b0, (16'h3000 + 16'(k)) ^ 16'h0F0F, (16'h4000 + 16'(k)) ^ 16'hF0F0});
    end
    fork
      begin
        bit ok0;
        for (int k = 0; k < 3; k++) begin
          drive_req(1'b0, 2'b01, 16'h2000 + 16'(k), 16'h1000 + 16'(k), 600, ok0);
          if (!ok0) acc_fail++;
        end
      end
      begin
        bit ok1;
        for (int k = 0; k < 3; k++) begin
          drive_req(1'b1, 2'b10, 16'h4000 + 16'(k), 16'h3000 + 16'(k), 600, ok1);
          if (!ok1) acc_fail++;
        end
      end
      begin
        bit   got;
        rsp_t e;
        for (int r = 0; r < 6; r++) begin
          wait_rsp(600, got);
          checks++;
          if (!got || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rr_rsp%0d: got no response expected one", r);
          end else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_err, rsp_data, rsp_key} !== {e.id, e.err, e.data, e.key}) begin
              errors++;
              $display("FAIL rr_rsp%0d: got %h expected %h", r, {rsp_id, rsp_err, rsp_data, rsp_key},
                       {e.id, e.err, e.data, e.key});
            end
          end
          @(negedge clk);
        end
      end
    join
    checks++;
    if (acc_fail != 0) begin errors++; $display("FAIL rr_accepts: got %0d stalls expected 0", acc_fail); end
    exp_q.delete();
  endtask

  task automatic test_illegal();
    bit   ok;
    int   bgn_seen = 0;
    rsp_t e;
    rsp_ready = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 16'h0000, 16'h0000});
    drive_req(1'b1, 2'b11, 16'hBEEF, 16'hCAFE, 20, ok);
    checks++;
    if (!ok || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL ill_latency: got accept=%0d valid=%b expected 1 1", ok, rsp_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({rsp_id, rsp_err, rsp_data, rsp_key} !== {e.id, e.err, e.data, e.key}) begin
        errors++;
        $display("FAIL ill_rsp: got %h expected %h", {rsp_id, rsp_err, rsp_data, rsp_key}, {e.id, e.err, e.data, e.key});
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (crypto_bgn !== 1'b0 || crypto_rst_n !== 1'b1) bgn_seen++;
      @(negedge clk);
    end
    checks++;
    if (bgn_seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ill_core_untouched: got %0d core cycles busy=%b expected 0 0", bgn_seen, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit   ok, got;
    rsp_t e;
    fin_delay = 5;
    xor_d = 16'h0F0F;
    xor_k = 16'hF0F0;
    rsp_ready = 1'b0;
    exp_q.push_back('{1'b0, 1'b0, 16'h2222 ^ 16'h0F0F, 16'h1111 ^ 16'hF0F0});
    drive_req(1'b0, 2'b01, 16'h1111, 16'h2222, 20, ok);
    wait_rsp(100, got);
    checks++;
    if (!ok || !got) begin errors++; $display("FAIL bp_first_rsp: got accept=%0d rsp=%0d expected 1 1", ok, got); end
    req1_mode = 2'b10; req1_key = 16'h3333; req1_data = 16'h4444; req1_valid = 1'b1;
    e = exp_q.pop_front();
    for (int i = 0; i < 15; i++) begin
      #1;
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data, rsp_key} !== {1'b1, e.id, e.err, e.data, e.key}) begin
        errors++;
        $display("FAIL bp_stable%0d: got %h expected %h", i, {rsp_valid, rsp_id, rsp_err, rsp_data, rsp_key},
                 {1'b1, e.id, e.err, e.data, e.key});
      end
      checks++;
      if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d: got %b expected 0", i, req1_ready); end
      @(negedge clk);
    end
    exp_q.push_back('{1'b1, 1'b0, 16'h4444 ^ 16'h0F0F, 16'h3333 ^ 16'hF0F0});
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_idle_gap: got valid/ready1=%b expected 01", {rsp_valid, req1_ready});
    end
    @(negedge clk);
    req1_valid = 1'b0;
    checks++;
    if ({busy, crypto_rst_n, crypto_mode} !== 4'b1010) begin
      errors++;
      $display("FAIL bp_accept: got busy/rst_n/mode=%b expected 1010", {busy, crypto_rst_n, crypto_mode});
    end
    wait_rsp(100, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_second_rsp: got none expected response");
    end else begin
      e = exp_q.pop_front();
      if ({rsp_id, rsp_err, rsp_data, rsp_key} !== {e.id, e.err, e.data, e.key}) begin
        errors++;
        $display("FAIL bp_second_rsp: got %h expected %h", {rsp_id, rsp_err, rsp_data, rsp_key}, {e.id, e.err, e.data, e.key});
      end
    end
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_timeout();
    int   wait_idx = -1, rsp_idx = -1, low_cnt = 0;
    logic prev_bgn = 1'b0;
    logic [33:0] got_rsp = '0;
    rsp_t e;
    to_rsp_ready = 1'b1;
    to_req0_mode = 2'b01; to_req0_key = 16'hA5A5; to_req0_data = 16'h5A5A; to_req0_valid = 1'b1;
    exp_q.push_back('{1'b0, 1'b1, 16'h0000, 16'h0000});
    #1;
    checks++;
    if (to_req0_ready !== 1'b1) begin errors++; $display("FAIL to_ready: got %b expected 1", to_req0_ready); end
    @(negedge clk);
    to_req0_valid = 1'b0;
    for (int idx = 0; idx < 100; idx++) begin
      if (prev_bgn && !to_bgn && wait_idx < 0) wait_idx = idx;
      if (wait_idx >= 0 && to_crst_n === 1'b0) low_cnt++;
      if (to_rsp_valid === 1'b1 && rsp_idx < 0) begin
        rsp_idx = idx;
        got_rsp = {to_rsp_id, to_rsp_err, to_rsp_data, to_rsp_key};
      end
      if (wait_idx >= 0 && idx >= wait_idx + 30) break;
      prev_bgn = to_bgn;
      @(negedge clk);
    end
    checks++;
    if (wait_idx < 0 || rsp_idx - wait_idx != 21) begin
      errors++;
      $display("FAIL to_latency: got rsp %0d cycles after WAIT (wait_idx %0d) expected 21", rsp_idx - wait_idx, wait_idx);
    end
    e = exp_q.pop_front();
    checks++;
    if (got_rsp !== {e.id, e.err, e.data, e.key}) begin
      errors++;
      $display("FAIL to_rsp: got %h expected %h", got_rsp, {e.id, e.err, e.data, e.key});
    end
    checks++;
    if (low_cnt != 1) begin errors++; $display("FAIL to_rst_pulse: got %0d low cycles expected 1", low_cnt); end
    exp_q.delete();
  endtask

  task automatic test_reset_midjob();
    bit ok;
    int found = 0;
    rsp_ready = 1'b1;
    drive_req(1'b1, 2'b10, 16'h7777, 16'h8888, 20, ok);
    for (int i = 0; i < 20; i++) begin
      if (crypto_bgn === 1'b1) begin found = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || found == 0) begin errors++; $display("FAIL mid_start: got accept=%0d start=%0d expected 1 1", ok, found); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, crypto_bgn, rsp_valid, crypto_rst_n} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: got busy/bgn/valid/rst_n=%b expected 0000", {busy, crypto_bgn, rsp_valid, crypto_rst_n});
    end
    rst = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_mode = 2'b01; req1_mode = 2'b01;
    #1;
    checks++;
    if ({busy, rsp_valid, crypto_rst_n, req0_ready, req1_ready} !== 5'b00110) begin
      errors++;
      $display("FAIL mid_tie_after_reset: got busy/valid/rst_n/rdy0/rdy1=%b expected 00110",
               {busy, rsp_valid, crypto_rst_n, req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_mode = '0; req0_key = '0; req0_data = '0;
    req1_valid = 1'b0; req1_mode = '0; req1_key = '0; req1_data = '0;
    rsp_ready = 1'b1;
    to_req0_valid = 1'b0; to_req0_mode = '0; to_req0_key = '0; to_req0_data = '0;
    to_req1_valid = 1'b0; to_req1_mode = '0; to_req1_key = '0; to_req1_data = '0;
    to_rsp_ready = 1'b1; to_fin = 1'b0; to_kout = 16'h5555; to_dout = 16'hAAAA;
    fin_delay = 40; xor_d = '0; xor_k = '0;
    crypto_data_out = '0; crypto_key_out = '0;
    @(negedge clk);
    test_reset();
    test_single_encrypt();
    test_contention();
    test_illegal();
    test_backpressure();
    test_timeout();
    test_reset_midjob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
